// File: rtl/hilo_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : hilo_sequencer_if
// Purpose  : CPU-side bundle of the HI/LO sequencer. It carries the mult/div
//            request, the mthi/mtlo writes, the HI/LO read path and the
//            busy/done/div_zero status.
// Revision : 1.0 - initial release
// ============================================================================
interface hilo_sequencer_if;
  logic        start;
  logic        op_div;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        done;
  logic        div_zero;

  // Control unit side: issues requests and writes, reads HI/LO and status
  modport master (
    output start, op_div, op_a, op_b, mthi, mtlo, hi_wdata, lo_wdata,
    input  hi_out, lo_out, busy, done, div_zero
  );

  // Sequencer side
  modport slave (
    input  start, op_div, op_a, op_b, mthi, mtlo, hi_wdata, lo_wdata,
    output hi_out, lo_out, busy, done, div_zero
  );
endinterface
`default_nettype wire

// File: rtl/hilo_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : hilo_sequencer
// Purpose  : Latches mult/div operands, runs the iterative Multdiv engine
//            through one LOAD cycle and a fixed number of RUN cycles, then
//            captures its Hi/Lo into the architectural HI/LO registers.
//            A divide by zero skips the engine and only flags div_zero.
//            Also serves mthi/mtlo writes while idle.
// Revision : 1.0 - initial release
// ============================================================================
module hilo_sequencer #(
  parameter int MULT_CYCLES = 33,
  parameter int DIV_CYCLES  = 33,
  parameter int CNT_W       = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  hilo_sequencer_if.slave   bus_if,
  input  logic [31:0]       md_hi_i,
  input  logic [31:0]       md_lo_i,
  output logic              md_cntrl_o,
  output logic              md_reset_o,
  output logic [31:0]       md_rega_o,
  output logic [31:0]       md_regb_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_RUN    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  state_t             state_q, state_d;
  logic               op_div_q, op_div_d;
  logic [31:0]        rega_q, rega_d;
  logic [31:0]        regb_q, regb_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dz_q, dz_d;
  logic               div_by_zero_w;

  assign div_by_zero_w = bus_if.op_div && (bus_if.op_b == 32'd0);

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand latches, run counter, divide-by-zero flag and HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_div_q <= 1'b0;
      rega_q   <= 32'd0;
      regb_q   <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      cnt_q    <= '0;
      dz_q     <= 1'b0;
    end else begin
      op_div_q <= op_div_d;
      rega_q   <= rega_d;
      regb_q   <= regb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      dz_q     <= dz_d;
    end
  end

  // Next-state and register update logic
  always_comb begin
    state_d  = state_q;
    op_div_d = op_div_q;
    rega_d   = rega_q;
    regb_d   = regb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    dz_d     = dz_q;
    case (state_q)
      S_IDLE: begin
        if (bus_if.start) begin
          // A request wins over any mthi/mtlo in the same cycle
          op_div_d = bus_if.op_div;
          rega_d   = bus_if.op_a;
          regb_d   = bus_if.op_b;
          dz_d     = div_by_zero_w;
          state_d  = div_by_zero_w ? S_FINISH : S_LOAD;
        end else begin
          if (bus_if.mthi) hi_d = bus_if.hi_wdata;
          if (bus_if.mtlo) lo_d = bus_if.lo_wdata;
        end
      end
      S_LOAD: begin
        cnt_d   = op_div_q ? DIV_LOAD : MULT_LOAD;
        state_d = S_RUN;
      end
      S_RUN: begin
        // Counter runs N..1, so RUN lasts exactly N cycles
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FINISH;
      end
      S_FINISH: begin
        if (!dz_q) begin
          hi_d = md_hi_i;
          lo_d = md_lo_i;
        end
        dz_d    = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus_if.busy     = (state_q != S_IDLE);
  assign bus_if.done     = (state_q == S_FINISH);
  assign bus_if.div_zero = (state_q == S_FINISH) && dz_q;
  assign bus_if.hi_out   = hi_q;
  assign bus_if.lo_out   = lo_q;

  // Engine is held in reset except while running; a divide by zero never
  // releases it
  assign md_reset_o = (state_q == S_IDLE) || (state_q == S_LOAD) ||
                      ((state_q == S_FINISH) && dz_q);
  assign md_cntrl_o = op_div_q;
  assign md_rega_o  = rega_q;
  assign md_regb_o  = regb_q;

endmodule
`default_nettype wire
